// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix lines plus decoded key outputs
interface keypad_scan_if;
    logic [3:0] col_in;
    logic [3:0] row_drive;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    modport master (output col_in, input row_drive, key_code, key_valid, key_held);
    modport slave  (input col_in, output row_drive, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 row-strobed keypad scanner with press/release debouncing
module keypad_scan #(
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 16
) (
    input logic          clk,
    input logic          rst,
    keypad_scan_if.slave kp
);
    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [8:0] DEB_LIM   = 9'(DEBOUNCE);
    state_t     state_q, state_d;
    logic [1:0] r_q, r_d, c_q, c_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic [8:0] cnt_inc;
    logic [1:0] low_idx;
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign low_idx = !kp.col_in[0] ? 2'd0 : !kp.col_in[1] ? 2'd1 : !kp.col_in[2] ? 2'd2 : 2'd3;
    // One counter serves settle, debounce and release; each state clears it on exit.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        case (state_q)
            S_SCAN: begin
                if (cnt_q == SETTLE_M1) begin
                    cnt_d = '0;
                    if (&kp.col_in) begin
                        r_d = r_q + 2'd1;
                    end else begin
                        c_d     = low_idx;
                        cnt_d   = 8'd1;
                        state_d = S_DEBOUNCE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DEBOUNCE: begin
                if (kp.col_in[c_q]) begin
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else if (cnt_inc >= DEB_LIM) begin
                    cnt_d   = '0;
                    code_d  = {r_q, c_q};
                    valid_d = 1'b1;
                    state_d = S_HELD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HELD: begin
                if (!kp.col_in[c_q]) begin
                    cnt_d = '0;
                end else if (cnt_inc >= DEB_LIM) begin
                    cnt_d   = '0;
                    r_d     = r_q + 2'd1;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_SCAN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SCAN;
            r_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end
    assign kp.row_drive = ~(4'b0001 << r_q);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = state_q == S_HELD;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: random keypad presses against a physical key-matrix model with a key-event scoreboard
module tb_keypad_scan;
    localparam int SETTLE   = 4;
    localparam int DEBOUNCE = 16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    keypad_scan_if kp();
    keypad_scan #(.SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)) dut (.clk(clk), .rst(rst), .kp(kp));
    always #5 clk = ~clk;
    // A pressed key shorts its row to its column, so a column reads low only while its row is strobed.
    always_comb begin
        kp.col_in = 4'hF;
        for (int i = 0; i < 4; i++)
            if (!kp.row_drive[i])
                for (int j = 0; j < 4; j++)
                    if (pressed[i*4+j]) kp.col_in[j] = 1'b0;
    end
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            check("one_cold", 16'($countones(~kp.row_drive)), 16'd1);
            if (kp.key_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got code %0d expected no pulse", kp.key_code);
                end else begin
                    check("key_code", 16'(kp.key_code), 16'(exp_q.pop_front()));
                    check("held_with_valid", 16'(kp.key_held), 16'd1);
                end
            end
        end
    end
    task automatic wait_held(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1 ok = kp.key_held;
        end
        check(name, 16'(ok), 16'd1);
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask
    // Releasing the accepted column must drop key_held after exactly DEBOUNCE cycles and step to the next row.
    task automatic release_check(input logic [15:0] mask, input int row, input int code);
        @(negedge clk);
        pressed = pressed & ~mask;
        repeat (DEBOUNCE - 1) @(posedge clk);
        #1 check("held_before_release", 16'(kp.key_held), 16'd1);
        @(posedge clk);
        #1 check("held_after_release", 16'(kp.key_held), 16'd0);
        check("row_after_release", 16'(kp.row_drive), 16'(~(4'b0001 << ((row + 1) % 4)) & 4'hF));
        check("code_retained", 16'(kp.key_code), 16'(code));
    endtask
    initial begin
        int k, row, a, b, g;
        repeat (2) @(posedge clk);
        #1;
        check("rst_row", 16'(kp.row_drive), 16'hE);
        check("rst_code", 16'(kp.key_code), 16'h0);
        check("rst_valid", 16'(kp.key_valid), 16'h0);
        check("rst_held", 16'(kp.key_held), 16'h0);
        @(negedge clk) rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1 check("idle_scan_row", 16'(kp.row_drive), 16'(~(4'b0001 << ((e / SETTLE) % 4)) & 4'hF));
        end
        // Reset lands on the debounce cycle that would have accepted key 0.
        @(negedge clk);
        rst = 1'b1;
        pressed = 16'h0001;
        @(negedge clk) rst = 1'b0;
        repeat (SETTLE + DEBOUNCE - 2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_deb_row", 16'(kp.row_drive), 16'hE);
        check("rst_deb_valid", 16'(kp.key_valid), 16'h0);
        check("rst_deb_held", 16'(kp.key_held), 16'h0);
        // Short press on key 0 is rejected and scanning restarts on row 0.
        @(negedge clk) rst = 1'b0;
        repeat (SETTLE + 5) @(posedge clk);
        @(negedge clk) pressed = '0;
        repeat (SETTLE) @(posedge clk);
        #1 check("bounce_row0", 16'(kp.row_drive), 16'hE);
        @(posedge clk);
        #1 check("bounce_row1", 16'(kp.row_drive), 16'hD);
        check("bounce_held", 16'(kp.key_held), 16'h0);
        for (int it = 0; it < 24; it++) begin
            idle($urandom_range(0, 12));
            case ($urandom_range(0, 3))
                0: begin
                    k = $urandom_range(0, 15);
                    pressed = 16'(1) << k;
                    exp_q.push_back(4'(k));
                    wait_held("steady_held");
                    idle($urandom_range(0, 20));
                    release_check(16'hFFFF, k / 4, k);
                end
                1: begin
                    row = $urandom_range(0, 3);
                    a = $urandom_range(0, 2);
                    b = $urandom_range(a + 1, 3);
                    pressed = (16'(1) << (row * 4 + a)) | (16'(1) << (row * 4 + b));
                    exp_q.push_back(4'(row * 4 + a));
                    wait_held("multi_held");
                    idle($urandom_range(0, 10));
                    release_check(16'(1) << (row * 4 + a), row, row * 4 + a);
                    exp_q.push_back(4'(row * 4 + b));
                    wait_held("multi_second_held");
                    release_check(16'hFFFF, row, row * 4 + b);
                end
                2: begin
                    k = $urandom_range(0, 15);
                    g = (it % 2 == 0) ? 10 : $urandom_range(1, DEBOUNCE - 1);
                    pressed = 16'(1) << k;
                    exp_q.push_back(4'(k));
                    wait_held("glitch_held");
                    @(negedge clk) pressed = '0;
                    repeat (g) @(posedge clk);
                    @(negedge clk) pressed = 16'(1) << k;
                    repeat (20) @(posedge clk);
                    #1 check("glitch_still_held", 16'(kp.key_held), 16'd1);
                    check("glitch_code", 16'(kp.key_code), 16'(k));
                    release_check(16'hFFFF, k / 4, k);
                end
                default: begin
                    k = $urandom_range(0, 15);
                    pressed = 16'(1) << k;
                    repeat ($urandom_range(1, DEBOUNCE - 1)) @(posedge clk);
                    @(negedge clk) pressed = '0;
                    repeat (40) @(posedge clk);
                    #1 check("short_press_held", 16'(kp.key_held), 16'd0);
                end
            endcase
        end
        idle(50);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
